// File: rtl/run_controller.sv
// Front-panel run/stop/single-step sequencer for the SSEM clock generator.
// Debounces the panel switches, runs the mode FSM and counts CPU clocks.
//
// Ports (all in the clk_in domain):
//   clk_in, reset        system clock, synchronous active-high reset
//   sw_run               raw RUN switch (1=run)
//   sw_step_mode         raw mode switch (1=single-step mode)
//   btn_step             raw momentary STEP button (1=pressed)
//   cpu_halt             CPU executed STP (level)
//   cpu_clk              clock generator clk_out, sampled as data
//   clear_count          synchronous clear of step_count
//   stop                 to clock generator stop
//   single_step          to clock generator single_step
//   single_stepping      to clock generator single_stepping
//   running              status: RUN, STEP_ARMED or STEP_PULSE
//   halted               status: HALTED
//   step_count           saturating count of cpu_clk rising edges
module run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned STEP_PULSE_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH       = 16
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   sw_run,
    input  logic                   sw_step_mode,
    input  logic                   btn_step,
    input  logic                   cpu_halt,
    input  logic                   cpu_clk,
    input  logic                   clear_count,
    output logic                   stop,
    output logic                   single_step,
    output logic                   single_stepping,
    output logic                   running,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] step_count
);

    localparam int unsigned DW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned PW =
        (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(STEP_PULSE_CYCLES - 1);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_ARMED,
        S_STEP_PULSE,
        S_HALTED
    } state_e;

    // ---------------- debounce ----------------
    // Bit 0 = sw_run, bit 1 = sw_step_mode, bit 2 = btn_step.
    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    db_q;
    logic [DW-1:0] db_cnt_q [3];
    logic          btn_prev_q;

    assign raw = {btn_step, sw_step_mode, sw_run};

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            btn_prev_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            btn_prev_q <= db_q[2];
            // A sample equal to the accepted value restarts the count,
            // so only an unbroken run of differing samples is accepted.
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    logic run_db;
    logic mode_db;
    logic step_req;

    assign run_db   = db_q[0];
    assign mode_db  = db_q[1];
    assign step_req = db_q[2] & ~btn_prev_q;

    // ---------------- mode FSM ----------------
    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] pulse_cnt_q;
    logic          pulse_done;

    assign pulse_done = (pulse_cnt_q == PULSE_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mode_db)     state_d = S_STEP_ARMED;
                else if (run_db) state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_halt)     state_d = S_HALTED;
                else if (mode_db) state_d = S_STEP_ARMED;
                else if (!run_db) state_d = S_IDLE;
            end
            S_STEP_ARMED: begin
                // Leaving step mode beats a same-cycle step request.
                if (cpu_halt)       state_d = S_HALTED;
                else if (!mode_db)  state_d = S_IDLE;
                else if (step_req)  state_d = S_STEP_PULSE;
            end
            S_STEP_PULSE: begin
                if (cpu_halt)        state_d = S_HALTED;
                else if (pulse_done) state_d = S_STEP_ARMED;
            end
            S_HALTED: begin
                if (!run_db && !mode_db) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // always match the Moore decode of state_q without a comb path.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pulse_cnt_q     <= '0;
            stop            <= 1'b1;
            single_step     <= 1'b0;
            single_stepping <= 1'b0;
            running         <= 1'b0;
            halted          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_STEP_PULSE && state_d == S_STEP_PULSE) begin
                pulse_cnt_q <= pulse_cnt_q + PW'(1);
            end else begin
                pulse_cnt_q <= '0;
            end
            stop            <= 1'b0;
            single_step     <= 1'b0;
            single_stepping <= 1'b0;
            running         <= 1'b0;
            halted          <= 1'b0;
            unique case (state_d)
                S_RUN: begin
                    running <= 1'b1;
                end
                S_STEP_ARMED: begin
                    single_stepping <= 1'b1;
                    running         <= 1'b1;
                end
                S_STEP_PULSE: begin
                    single_step     <= 1'b1;
                    single_stepping <= 1'b1;
                    running         <= 1'b1;
                end
                S_HALTED: begin
                    stop   <= 1'b1;
                    halted <= 1'b1;
                end
                default: begin
                    stop <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- cycle counter ----------------
    logic cpu_clk_d_q;
    logic cpu_edge;

    assign cpu_edge = cpu_clk & ~cpu_clk_d_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cpu_clk_d_q <= 1'b0;
            step_count  <= '0;
        end else begin
            cpu_clk_d_q <= cpu_clk;
            if (clear_count) begin
                step_count <= '0;
            end else if (cpu_edge && step_count != COUNT_MAX) begin
                step_count <= step_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller with short debounce,
// 2-cycle step pulse and a 4-bit saturating counter.
module tb_run_controller;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       sw_run = 1'b0;
    logic       sw_step_mode = 1'b0;
    logic       btn_step = 1'b0;
    logic       cpu_halt = 1'b0;
    logic       cpu_clk = 1'b0;
    logic       clear_count = 1'b0;
    logic       stop;
    logic       single_step;
    logic       single_stepping;
    logic       running;
    logic       halted;
    logic [3:0] step_count;

    int checks = 0;
    int failures = 0;

    bit         exp_bit_q [$];
    logic [3:0] exp_cnt_q [$];

    always #5 clk_in = ~clk_in;

    run_controller #(
        .DEBOUNCE_CYCLES  (4),
        .STEP_PULSE_CYCLES(2),
        .COUNT_WIDTH      (4)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .sw_run         (sw_run),
        .sw_step_mode   (sw_step_mode),
        .btn_step       (btn_step),
        .cpu_halt       (cpu_halt),
        .cpu_clk        (cpu_clk),
        .clear_count    (clear_count),
        .stop           (stop),
        .single_step    (single_step),
        .single_stepping(single_stepping),
        .running        (running),
        .halted         (halted),
        .step_count     (step_count)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        sw_run       = 1'b0;
        sw_step_mode = 1'b0;
        btn_step     = 1'b0;
        cpu_halt     = 1'b0;
        cpu_clk      = 1'b0;
        clear_count  = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({stop, single_step, single_stepping, running, halted}
            !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=10000",
                {stop, single_step, single_stepping, running, halted});
        end
        checks++;
        if (step_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", step_count);
        end
    endtask

    task automatic test_run_start();
        bit e;
        int n;
        do_reset();
        sw_run = 1'b1;
        for (int i = 0; i < 6; i++) exp_bit_q.push_back(1'b1);
        exp_bit_q.push_back(1'b0);
        n = 0;
        while (exp_bit_q.size() > 0) begin
            tick();
            n++;
            e = exp_bit_q.pop_front();
            checks++;
            if (stop !== e) begin
                failures++;
                $display("FAIL run_start_stop cyc=%0d got=%b exp=%b",
                    n, stop, e);
            end
        end
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL run_start_running got=%b exp=1", running);
        end
        sw_run = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        sw_run = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 3) sw_run = 1'b0;
            checks++;
            if (stop !== 1'b1 || running !== 1'b0) begin
                failures++;
                $display("FAIL glitch cyc=%0d stop=%b running=%b exp=1/0",
                    i, stop, running);
            end
        end
    endtask

    task automatic test_single_step();
        bit e;
        do_reset();
        sw_step_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if ({stop, single_stepping, running} !== 3'b011) begin
            failures++;
            $display("FAIL step_armed got=%b exp=011",
                {stop, single_stepping, running});
        end
        for (int i = 1; i <= 25; i++) begin
            exp_bit_q.push_back(i == 7 || i == 8);
        end
        btn_step = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            // Short re-press glitch while the pulse is active.
            if (i == 7)  btn_step = 1'b0;
            if (i == 8)  btn_step = 1'b1;
            if (i == 10) btn_step = 1'b0;
            e = exp_bit_q.pop_front();
            checks++;
            if (single_step !== e) begin
                failures++;
                $display("FAIL step_pulse cyc=%0d got=%b exp=%b",
                    i, single_step, e);
            end
        end
        checks++;
        if ({stop, single_stepping} !== 2'b01) begin
            failures++;
            $display("FAIL step_after got=%b exp=01",
                {stop, single_stepping});
        end
    endtask

    task automatic test_halt();
        do_reset();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_idle_ignored got=%b exp=0", halted);
        end
        sw_run = 1'b1;
        repeat (7) tick();
        checks++;
        if ({stop, running} !== 2'b01) begin
            failures++;
            $display("FAIL halt_run got=%b exp=01", {stop, running});
        end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        checks++;
        if ({stop, halted, running} !== 3'b110) begin
            failures++;
            $display("FAIL halt_enter got=%b exp=110",
                {stop, halted, running});
        end
        repeat (10) tick();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold got=%b exp=1", halted);
        end
        sw_run = 1'b0;
        repeat (6) tick();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_release_early got=%b exp=1", halted);
        end
        tick();
        checks++;
        if ({stop, halted, running} !== 3'b100) begin
            failures++;
            $display("FAIL halt_to_idle got=%b exp=100",
                {stop, halted, running});
        end
        sw_run = 1'b1;
        repeat (6) tick();
        checks++;
        if (stop !== 1'b1) begin
            failures++;
            $display("FAIL rerun_early got=%b exp=1", stop);
        end
        tick();
        checks++;
        if ({stop, running} !== 2'b01) begin
            failures++;
            $display("FAIL rerun got=%b exp=01", {stop, running});
        end
        sw_run = 1'b0;
    endtask

    task automatic test_count();
        logic [3:0] e;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            cpu_clk = 1'b1;
            exp_cnt_q.push_back((n > 15) ? 4'd15 : 4'(n));
            tick();
            e = exp_cnt_q.pop_front();
            checks++;
            if (step_count !== e) begin
                failures++;
                $display("FAIL count edge=%0d got=%0d exp=%0d",
                    n, step_count, e);
            end
            cpu_clk = 1'b0;
            tick();
        end
        cpu_clk     = 1'b1;
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        checks++;
        if (step_count !== 4'd0) begin
            failures++;
            $display("FAIL count_clear got=%0d exp=0", step_count);
        end
        cpu_clk = 1'b0;
        tick();
        cpu_clk = 1'b1;
        tick();
        cpu_clk = 1'b0;
        checks++;
        if (step_count !== 4'd1) begin
            failures++;
            $display("FAIL count_after_clear got=%0d exp=1", step_count);
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit seen;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            cpu_clk = 1'b1;
            tick();
            cpu_clk = 1'b0;
            tick();
        end
        sw_step_mode = 1'b1;
        repeat (7) tick();
        btn_step = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (single_step === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midpulse_wait got=no_pulse exp=pulse");
        end
        checks++;
        if (step_count !== 4'd3) begin
            failures++;
            $display("FAIL midpulse_count got=%0d exp=3", step_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({stop, single_step, single_stepping, running}
            !== 4'b1000) begin
            failures++;
            $display("FAIL midpulse_reset got=%b exp=1000",
                {stop, single_step, single_stepping, running});
        end
        checks++;
        if (step_count !== 4'd0) begin
            failures++;
            $display("FAIL midpulse_reset_count got=%0d exp=0",
                step_count);
        end
        btn_step     = 1'b0;
        sw_step_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_start();
        test_glitch();
        test_single_step();
        test_halt();
        test_count();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
